div_clk_monitor: RTL and testbench
==================================

# div_clk_monitor

Period-measurement monitor that sits directly downstream of the divide-by-two flip-flop stage. It samples that stage's output (or any slow toggling signal) into the `cl` domain and measures the cl-cycle span of NUM_PERIODS consecutive periods. It reports the result with a pass/fail check against an expected ratio and flags stuck or missing input as a timeout.

## Interface
- SYNC_STAGES, 2: synchronizer depth for sig_in; must be ≥2.
- NUM_PERIODS, 4: periods measured per run; range 1..255.
- CNT_W, 16: width of cycle counters and result.
- TIMEOUT_CYC, 1024: maximum cl cycles allowed between rises before abort; must be < 2^CNT_W.
- EXP_PERIOD, 2: expected sig_in period in cl cycles.
- TOL, 0: allowed ± deviation of result from EXP_PERIOD*NUM_PERIODS.
- cl, input, 1: clock; all logic on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- sig_in, input, 1: monitored signal, treated as asynchronous.
- start, input, 1: one-cycle request to begin a measurement; ignored unless idle.
- busy, output, 1: measurement in progress.
- done, output, 1: one-cycle pulse when a run ends.
- result, output, CNT_W: measured cl cycles across NUM_PERIODS periods; held until next start.
- ok, output, 1: result within tolerance and no timeout/overflow; held.
- timeout, output, 1: run aborted for lack of edges; held.
- overflow, output, 1: cycle counter saturated; held.

## Operation
- Front end:
  - sig_in passes through SYNC_STAGES flops (reset 0), then a delay flop.
  - rise = sync_out & ~delayed.
- States are IDLE, ARM, MEAS and DONE.
- IDLE: start=1 → ARM. Clear result, ok, timeout, overflow, gap counter and period counter on the same edge.
- ARM: wait for the first rise.
  - On rise → MEAS, with cyc_cnt←1 and gap←0.
  - The gap counter increments each cycle. If gap reaches TIMEOUT_CYC-1 with no rise → DONE with timeout←1 and result←0.
- MEAS:
  - cyc_cnt increments every cycle and saturates at all-ones; overflow←1 on saturation.
  - gap←0 on each rise.
  - Each rise increments per_cnt.
  - On the rise where per_cnt==NUM_PERIODS-1 → DONE, with result←cyc_cnt (cycle distance from first rise to last rise).
  - Timeout behaves as in ARM, with result←0.
- DONE: lasts one cycle, then → IDLE.
  - ok is computed combinationally from the held result, registered on entry to DONE.
  - ok = !timeout && !overflow && |result − EXP_PERIOD*NUM_PERIODS| ≤ TOL.
- Arithmetic: compare in CNT_W+1 bits; no wrap. EXP_PERIOD*NUM_PERIODS must fit in CNT_W (elaboration check).
- start while busy: ignored; no restart, no effect on outputs.
- rise and timeout in the same cycle: the rise wins.
- Reset at any time: all state and outputs go to 0 asynchronously. No done is emitted for an interrupted run.

## Timing
- Reset values:
  - busy=0, done=0, result=0, ok=0, timeout=0, overflow=0.
  - FSM=IDLE; synchronizer flops = 0.
- busy = (state != IDLE) and is registered. It rises the cycle after start is sampled and falls the cycle after done.
- done is high exactly for the cycle state==DONE.
- Edge latency: a sig_in rise on a cl edge produces rise SYNC_STAGES+1 cycles later.
- done asserts 1 cycle after the final rise.
- result, ok, timeout and overflow become valid in the same cycle as done and stay stable until the next accepted start.

## Structure
- Shared package `clkdiv_pkg`: state enum (IDLE, ARM, MEAS, DONE) and default parameter constants (NUM_PERIODS, TIMEOUT_CYC, EXP_PERIOD).
- One sub-module, `edge_sync`: parameterised synchronizer plus rising-edge detector. It takes cl, rst_n and sig_in, and outputs rise.
- The FSM, counters and compare logic live in the top module.

## Test plan
- Divide-by-two stage clocked from the same cl drives sig_in, defaults used, start pulsed → done after one run; result=8, ok=1, timeout=0.
- sig_in with period 3 cl → result=12, ok=0. Repeat with TOL=4 → ok=1.
- sig_in held at 0, start pulsed → done exactly TIMEOUT_CYC cycles after entering ARM; timeout=1, result=0, ok=0.
- start pulsed again mid-MEAS → no restart, and the original result is still 8. Then start is accepted in the cycle after done returns to IDLE.
- rst_n dropped mid-MEAS → all outputs 0 immediately, no done pulse. After release, a fresh run yields result=8.
- CNT_W=4, sig_in period 6 → overflow=1, result=15, ok=0.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and default constants for the divided-clock period monitor.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_PERIODS = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_EXP_PERIOD  = 2;

endpackage

// File: rtl/div_clk_monitor_if.sv
// Control/result bundle between a requester and the period monitor.
interface div_clk_monitor_if #(
    parameter int CNT_W = 16
);
    // Handshake: start is a one-cycle request, accepted only while busy is low;
    // every accepted run ends with exactly one done pulse, and result/ok/timeout/
    // overflow are valid from that pulse until the next accepted start.
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] result;
    logic             ok;
    logic             timeout;
    logic             overflow;

    modport master (output start, input busy, done, result, ok, timeout, overflow);
    modport slave  (input start, output busy, done, result, ok, timeout, overflow);
endinterface

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic cl,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise
);
    if (SYNC_STAGES < 2) begin : g_bad_depth
        $error("edge_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed_q;

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            delayed_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
            delayed_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~delayed_q;
endmodule

// File: rtl/div_clk_monitor.sv
// Measures the cl-cycle span of NUM_PERIODS periods of a slow input and checks it
// against EXP_PERIOD*NUM_PERIODS +/- TOL, aborting on a missing or stuck input.
module div_clk_monitor
    import clkdiv_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_PERIODS = DEF_NUM_PERIODS,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
    parameter int TOL         = 0
) (
    input  logic               cl,
    input  logic               rst_n,
    input  logic               sig_in,
    div_clk_monitor_if.slave   mon,
    output state_t             state_dbg
);
    if (NUM_PERIODS < 1 || NUM_PERIODS > 255) begin : g_bad_num
        $error("div_clk_monitor: NUM_PERIODS out of range 1..255");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_bad_tmo
        $error("div_clk_monitor: TIMEOUT_CYC must be in 1..2^CNT_W-1");
    end
    if (EXP_PERIOD * NUM_PERIODS >= (1 << CNT_W)) begin : g_bad_exp
        $error("div_clk_monitor: EXP_PERIOD*NUM_PERIODS does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CYC_MAX   = '1;
    localparam logic [7:0]       LAST_PER  = 8'(NUM_PERIODS - 1);
    localparam logic [CNT_W:0]   EXP_TOTAL = (CNT_W+1)'(EXP_PERIOD * NUM_PERIODS);
    localparam logic [CNT_W:0]   TOL_W     = (CNT_W+1)'(TOL);

    logic rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .cl     (cl),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .rise   (rise)
    );

    state_t           state_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] cyc_q;
    logic [7:0]       per_q;
    logic [CNT_W-1:0] result_q;
    logic             busy_q, done_q, ok_q, timeout_q, overflow_q;

    // Distance is taken one bit wider than the counter so it can never wrap.
    function automatic logic ok_calc(input logic [CNT_W-1:0] res, input logic ov);
        logic [CNT_W:0] r;
        logic [CNT_W:0] d;
        r = {1'b0, res};
        d = (r >= EXP_TOTAL) ? (r - EXP_TOTAL) : (EXP_TOTAL - r);
        return !ov && (d <= TOL_W);
    endfunction

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            cyc_q      <= '0;
            per_q      <= '0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mon.start) begin
                        state_q    <= ARM;
                        busy_q     <= 1'b1;
                        result_q   <= '0;
                        ok_q       <= 1'b0;
                        timeout_q  <= 1'b0;
                        overflow_q <= 1'b0;
                        gap_q      <= '0;
                        per_q      <= '0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state_q <= MEAS;
                        cyc_q   <= CNT_W'(1);
                        gap_q   <= '0;
                    end else if (gap_q == GAP_LIMIT) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        result_q  <= '0;
                        ok_q      <= 1'b0;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                MEAS: begin
                    if (rise && per_q == LAST_PER) begin
                        // The final rise closes the window; cyc_q is first-to-last distance.
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= cyc_q;
                        ok_q     <= ok_calc(cyc_q, overflow_q);
                        gap_q    <= '0;
                    end else if (!rise && gap_q == GAP_LIMIT) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        result_q  <= '0;
                        ok_q      <= 1'b0;
                    end else begin
                        if (rise) begin
                            per_q <= per_q + 1'b1;
                            gap_q <= '0;
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                        if (cyc_q == CYC_MAX) begin
                            overflow_q <= 1'b1;
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mon.busy     = busy_q;
    assign mon.done     = done_q;
    assign mon.result   = result_q;
    assign mon.ok       = ok_q;
    assign mon.timeout  = timeout_q;
    assign mon.overflow = overflow_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: three configurations driven by generated periodic inputs.
module tb_div_clk_monitor;
    import clkdiv_pkg::*;

    // ---------------- clock / reset ----------------
    logic cl = 1'b0;
    logic rst_n = 1'b0;
    always #5 cl = ~cl;

    int unsigned cyc = 0;
    always @(posedge cl) cyc++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    // 0: defaults, 1: TOL=4, 2: CNT_W=4 with TIMEOUT_CYC=15
    localparam int NUM = 4;
    localparam int EXP = 2;
    localparam int CW[3]   = '{16, 16, 4};
    localparam int TOLS[3] = '{0, 4, 0};
    localparam int TMO[3]  = '{1024, 1024, 15};

    int   per[3];
    int   ph[3];
    logic sig[3];
    state_t st_a, st_b, st_c;

    div_clk_monitor_if #(.CNT_W(16)) if_a ();
    div_clk_monitor_if #(.CNT_W(16)) if_b ();
    div_clk_monitor_if #(.CNT_W(4))  if_c ();

    div_clk_monitor u_a (.cl(cl), .rst_n(rst_n), .sig_in(sig[0]), .mon(if_a.slave), .state_dbg(st_a));
    div_clk_monitor #(.TOL(4)) u_b (.cl(cl), .rst_n(rst_n), .sig_in(sig[1]), .mon(if_b.slave), .state_dbg(st_b));
    div_clk_monitor #(.CNT_W(4), .TIMEOUT_CYC(15)) u_c (.cl(cl), .rst_n(rst_n), .sig_in(sig[2]), .mon(if_c.slave), .state_dbg(st_c));

    // Periodic input generators: period per[i] cl cycles, held low when per[i] < 2.
    initial begin
        for (int i = 0; i < 3; i++) begin
            per[i] = 0;
            ph[i]  = 0;
            sig[i] = 1'b0;
        end
    end
    always @(negedge cl) begin
        for (int i = 0; i < 3; i++) begin
            if (per[i] < 2) begin
                sig[i] = 1'b0;
                ph[i]  = 0;
            end else begin
                sig[i] = (ph[i] < per[i] / 2);
                ph[i]  = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int fails  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic        busy;
        logic        done;
        logic [15:0] result;
        logic        ok;
        logic        timeout;
        logic        overflow;
    } obs_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t get_obs(input int i);
        obs_t o;
        case (i)
            0: begin
                o.busy = if_a.busy; o.done = if_a.done; o.result = if_a.result;
                o.ok = if_a.ok; o.timeout = if_a.timeout; o.overflow = if_a.overflow;
            end
            1: begin
                o.busy = if_b.busy; o.done = if_b.done; o.result = if_b.result;
                o.ok = if_b.ok; o.timeout = if_b.timeout; o.overflow = if_b.overflow;
            end
            default: begin
                o.busy = if_c.busy; o.done = if_c.done; o.result = {12'd0, if_c.result};
                o.ok = if_c.ok; o.timeout = if_c.timeout; o.overflow = if_c.overflow;
            end
        endcase
        return o;
    endfunction

    // Reference: a steady input of period p spans num*p cycles over num periods.
    task automatic model(input int i, input int p, output logic [15:0] res,
                         output logic ok, output logic to, output logic ov);
        int total, maxv, d;
        if (p < 2 || p > TMO[i]) begin
            res = '0; ok = 1'b0; to = 1'b1; ov = 1'b0;
        end else begin
            total = NUM * p;
            maxv  = (1 << CW[i]) - 1;
            ov    = (total > maxv);
            res   = 16'(ov ? maxv : total);
            d     = int'(res) - EXP * NUM;
            if (d < 0) d = -d;
            to    = 1'b0;
            ok    = !ov && (d <= TOLS[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_start(input int i, input logic v);
        case (i)
            0: if_a.start = v;
            1: if_b.start = v;
            default: if_c.start = v;
        endcase
    endtask

    task automatic pulse_start(input int i);
        @(negedge cl);
        set_start(i, 1'b1);
        @(negedge cl);
        set_start(i, 1'b0);
    endtask

    task automatic wait_done(input int i, input int budget, output obs_t o, output int lat);
        int t0;
        bit seen;
        t0   = int'(cyc);
        seen = 1'b0;
        o    = get_obs(i);
        for (int k = 0; k < budget; k++) begin
            @(negedge cl);
            o = get_obs(i);
            if (o.done) begin
                seen = 1'b1;
                break;
            end
        end
        lat = int'(cyc) - t0;
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run(input int i, input int p, input string tag);
        obs_t o;
        int lat;
        logic [15:0] e_res;
        logic e_ok, e_to, e_ov;
        per[i] = p;
        repeat (3 * p + 4) @(negedge cl);
        model(i, p, e_res, e_ok, e_to, e_ov);
        exp_q.push_back(e_res);
        pulse_start(i);
        wait_done(i, 200, o, lat);
        check({tag, "_result"}, 32'(o.result), 32'(exp_q.pop_front()));
        check({tag, "_ok"}, 32'(o.ok), 32'(e_ok));
        check({tag, "_timeout"}, 32'(o.timeout), 32'(e_to));
        check({tag, "_overflow"}, 32'(o.overflow), 32'(e_ov));
        @(negedge cl);
        o = get_obs(i);
        check({tag, "_done_width"}, 32'(o.done), 32'd0);
        check({tag, "_busy_after"}, 32'(o.busy), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        obs_t o;
        int lat;
        int i, p;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if_c.start = 1'b0;

        repeat (3) @(negedge cl);
        o = get_obs(0);
        check("rst_busy", 32'(o.busy), 32'd0);
        check("rst_done", 32'(o.done), 32'd0);
        check("rst_result", 32'(o.result), 32'd0);
        check("rst_ok", 32'(o.ok), 32'd0);
        check("rst_timeout", 32'(o.timeout), 32'd0);
        check("rst_overflow", 32'(o.overflow), 32'd0);
        check("rst_state", 32'(st_a), 32'(IDLE));
        rst_n = 1'b1;

        run(0, 2, "div2");
        run(0, 3, "p3_tol0");
        run(1, 3, "p3_tol4");
        run(2, 6, "ovf");

        // Input stuck low: abort exactly TIMEOUT_CYC cycles after entering ARM.
        per[0] = 0;
        repeat (4) @(negedge cl);
        pulse_start(0);
        check("tmo_busy", 32'(if_a.busy), 32'd1);
        wait_done(0, 1100, o, lat);
        check("tmo_latency", 32'(lat), 32'd1024);
        check("tmo_timeout", 32'(o.timeout), 32'd1);
        check("tmo_result", 32'(o.result), 32'd0);
        check("tmo_ok", 32'(o.ok), 32'd0);

        // A second start during MEAS must not restart the run.
        per[0] = 2;
        repeat (8) @(negedge cl);
        pulse_start(0);
        repeat (4) @(negedge cl);
        check("mid_state", 32'(st_a), 32'(MEAS));
        pulse_start(0);
        wait_done(0, 200, o, lat);
        check("mid_result", 32'(o.result), 32'd8);
        check("mid_ok", 32'(o.ok), 32'd1);
        // Start in the first idle cycle after done is accepted.
        pulse_start(0);
        check("reaccept_busy", 32'(if_a.busy), 32'd1);
        wait_done(0, 200, o, lat);
        check("reaccept_result", 32'(o.result), 32'd8);

        // Reset in the middle of a measurement.
        @(negedge cl);
        pulse_start(0);
        repeat (4) @(negedge cl);
        rst_n = 1'b0;
        #1;
        o = get_obs(0);
        check("arst_busy", 32'(o.busy), 32'd0);
        check("arst_result", 32'(o.result), 32'd0);
        check("arst_ok", 32'(o.ok), 32'd0);
        check("arst_state", 32'(st_a), 32'(IDLE));
        for (int k = 0; k < 3; k++) begin
            @(negedge cl);
            check("arst_no_done", 32'(if_a.done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge cl);
        check("arst_no_done_after", 32'(if_a.done), 32'd0);
        run(0, 2, "post_rst");

        // Randomized periods on randomly chosen configurations.
        for (int n = 0; n < 8; n++) begin
            i = int'($urandom_range(0, 2));
            p = (i == 2) ? int'($urandom_range(2, 9)) : int'($urandom_range(2, 12));
            run(i, p, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
